// File: rtl/gpr_mp.sv
// gpr_mp: multi-port register file with pending-write scoreboard and optional write->read bypass.
// Define GPR_EXIT_CHECK_EN to add the ecall exit detector (ecall/halt_valid/halt_code).
module gpr_mp #(
   parameter int XLEN = 32,
   parameter int NREGS = 32,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 1,
   parameter bit BYPASS = 1'b1,
   localparam int AW = $clog2(NREGS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_RD*AW-1:0]   rd_addr,
   output logic [NUM_RD*XLEN-1:0] rd_data,
   output logic [NUM_RD-1:0]      rd_busy,
   input  logic [NUM_WR-1:0]      wr_en,
   input  logic [NUM_WR*AW-1:0]   wr_addr,
   input  logic [NUM_WR*XLEN-1:0] wr_data,
   input  logic                   alloc_en,
   input  logic [AW-1:0]          alloc_addr,
   input  logic                   flush
`ifdef GPR_EXIT_CHECK_EN
   ,
   input  logic                   ecall,
   output logic                   halt_valid,
   output logic [XLEN-1:0]        halt_code
`endif
);
   logic [XLEN-1:0] regs [NREGS];
   logic [XLEN-1:0] regs_n [NREGS];
   logic [NREGS-1:0] pend, pend_n, hit;

   function automatic logic live(input logic [AW-1:0] a);
      return a != '0 && 32'(a) < NREGS;
   endfunction

   // ascending port order makes the highest-index writer win
   always_comb begin
      regs_n = regs;
      hit = '0;
      for (int w = 0; w < NUM_WR; w++) begin
         if (wr_en[w] && live(wr_addr[w*AW +: AW])) begin
            regs_n[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
            hit[wr_addr[w*AW +: AW]] = 1'b1;
         end
      end
      pend_n = pend & ~hit;
      if (alloc_en && live(alloc_addr)) pend_n[alloc_addr] = 1'b1;
      if (flush) pend_n = '0;
   end

   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      logic [AW-1:0] a;
      assign a = rd_addr[r*AW +: AW];
      assign rd_data[r*XLEN +: XLEN] = !live(a) ? '0 : BYPASS ? regs_n[a] : regs[a];
      assign rd_busy[r] = live(a) && pend[a] && !(BYPASS && hit[a]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs <= '{default: '0};
         pend <= '0;
      end else begin
         regs <= regs_n;
         pend <= pend_n;
      end
   end

`ifdef GPR_EXIT_CHECK_EN
   logic exit_hit;
   assign exit_hit = ecall && !halt_valid && regs[17] == XLEN'(93);

   always_ff @(posedge clk) begin
      if (rst) begin
         halt_valid <= 1'b0;
         halt_code <= '0;
      end else if (exit_hit) begin
         halt_valid <= 1'b1;
         halt_code <= regs[10];
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) if (!rst && exit_hit) $display("%s", regs[10] == '0 ? "Pass!!!" : "Fail!!!");
`endif
`endif
endmodule

// File: tb/tb_gpr_mp.sv
// tb_gpr_mp: directed vector table plus randomized run against a behavioural register-file model.
module tb_gpr_mp;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, alloc_en, flush, ecall;
   logic [1:0] wr_en;
   logic [9:0] wr_addr, rd_addr;
   logic [63:0] wr_data, rd_data_a, rd_data_b;
   logic [4:0] alloc_addr;
   logic [1:0] rd_busy_a, rd_busy_b;
`ifdef GPR_EXIT_CHECK_EN
   logic hv_a, hv_b;
   logic [31:0] hc_a, hc_b;
`endif

   gpr_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b1)) dut_a (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush)
`ifdef GPR_EXIT_CHECK_EN
      , .ecall(ecall), .halt_valid(hv_a), .halt_code(hc_a)
`endif
   );

   gpr_mp #(.XLEN(32), .NREGS(24), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b0)) dut_b (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush)
`ifdef GPR_EXIT_CHECK_EN
      , .ecall(ecall), .halt_valid(hv_b), .halt_code(hc_b)
`endif
   );

   int pass_n = 0;
   int total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // model: index 0 is the 32-entry bypassed file, index 1 the 24-entry registered one
   logic [31:0] mreg [2][32];
   bit mpend [2][32];

   function automatic int nr(input int c);
      return c == 0 ? 32 : 24;
   endfunction

   task automatic model_rd(input int c, input logic [4:0] a, output logic [31:0] d, output logic b);
      d = '0;
      b = 1'b0;
      if (a != 0 && int'(a) < nr(c)) begin
         d = mreg[c][a];
         b = mpend[c][a];
         if (c == 0)
            for (int w = 0; w < 2; w++)
               if (wr_en[w] && wr_addr[w*5 +: 5] == a) begin
                  d = wr_data[w*32 +: 32];
                  b = 1'b0;
               end
      end
   endtask

   task automatic model_step();
      for (int c = 0; c < 2; c++) begin
         if (rst) begin
            for (int i = 0; i < 32; i++) begin
               mreg[c][i] = '0;
               mpend[c][i] = 1'b0;
            end
         end else begin
            for (int w = 0; w < 2; w++) begin
               logic [4:0] a;
               a = wr_addr[w*5 +: 5];
               if (wr_en[w] && a != 0 && int'(a) < nr(c)) begin
                  mreg[c][a] = wr_data[w*32 +: 32];
                  mpend[c][a] = 1'b0;
               end
            end
            if (alloc_en && alloc_addr != 0 && int'(alloc_addr) < nr(c)) mpend[c][alloc_addr] = 1'b1;
            if (flush) for (int i = 0; i < 32; i++) mpend[c][i] = 1'b0;
         end
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] d;
      logic b;
      for (int c = 0; c < 2; c++)
         for (int p = 0; p < 2; p++) begin
            model_rd(c, rd_addr[p*5 +: 5], d, b);
            chk($sformatf("%s dut%0d p%0d data", tag, c, p), c == 0 ? rd_data_a[p*32 +: 32] : rd_data_b[p*32 +: 32], d);
            chk($sformatf("%s dut%0d p%0d busy", tag, c, p), 32'(c == 0 ? rd_busy_a[p] : rd_busy_b[p]), 32'(b));
         end
   endtask

   task automatic idle();
      wr_en = '0;
      wr_addr = '0;
      wr_data = '0;
      alloc_en = 1'b0;
      alloc_addr = '0;
      flush = 1'b0;
      rd_addr = '0;
   endtask

   typedef struct {
      logic [1:0] we;
      logic [4:0] wa0, wa1, aa, ra;
      logic [31:0] wd0, wd1, ea, eb;
      logic al, fl, ba, bb;
   } vec_t;

   function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0, logic [4:0] wa1,
                               logic [31:0] wd1, logic al, logic [4:0] aa, logic fl, logic [4:0] ra,
                               logic [31:0] ea, logic ba, logic [31:0] eb, logic bb);
      vec_t v;
      v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
      v.al = al; v.aa = aa; v.fl = fl; v.ra = ra;
      v.ea = ea; v.ba = ba; v.eb = eb; v.bb = bb;
      return v;
   endfunction

   function automatic logic [4:0] raddr();
      return $urandom_range(0, 3) == 0 ? 5'($urandom_range(22, 31)) : 5'($urandom_range(0, 9));
   endfunction

   vec_t tbl[$];

   initial begin
      // columns: we wa0 wd0 wa1 wd1 | al aa fl | ra | exp_a busy_a | exp_b busy_b
      tbl.push_back(mk(2'b01, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 5, 32'h1234_5678, 0, 32'h0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 32'h1234_5678, 0, 32'h1234_5678, 0));
      tbl.push_back(mk(2'b11, 7, 32'hA, 7, 32'hB, 0, 0, 0, 7, 32'hB, 0, 32'h0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 32'hB, 0, 32'hB, 0));
      tbl.push_back(mk(2'b01, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 9, 0, 9, 32'h0, 0, 32'h0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 32'h0, 1, 32'h0, 1));
      tbl.push_back(mk(2'b01, 9, 32'h99, 0, 0, 1, 9, 0, 9, 32'h99, 0, 32'h0, 1));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 32'h99, 1, 32'h99, 1));
      tbl.push_back(mk(2'b01, 9, 32'h55, 0, 0, 0, 0, 0, 9, 32'h55, 0, 32'h99, 1));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 32'h55, 0, 32'h55, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 3, 1, 3, 32'h0, 0, 32'h0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 3, 32'h0, 0, 32'h0, 0));
      tbl.push_back(mk(2'b10, 0, 0, 25, 32'hDEAD, 0, 0, 0, 25, 32'hDEAD, 0, 32'h0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 25, 32'hDEAD, 0, 32'h0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 4, 0, 4, 32'h0, 0, 32'h0, 0));
      tbl.push_back(mk(2'b01, 4, 32'h44, 0, 0, 0, 0, 1, 4, 32'h44, 0, 32'h0, 1));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 4, 32'h44, 0, 32'h44, 0));
      tbl.push_back(mk(2'b11, 20, 32'h20, 28, 32'h28, 0, 0, 0, 20, 32'h20, 0, 32'h0, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 20, 32'h20, 0, 32'h20, 0));

      rst = 1'b1;
      ecall = 1'b0;
      idle();
      model_step();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         rd_addr = {5'(i + 16), 5'(i)};
         #1;
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("reset a%0d data", i + 16*p), rd_data_a[p*32 +: 32], 32'h0);
            chk($sformatf("reset a%0d busy", i + 16*p), 32'(rd_busy_a[p]), 32'h0);
            chk($sformatf("reset b%0d data", i + 16*p), rd_data_b[p*32 +: 32], 32'h0);
            chk($sformatf("reset b%0d busy", i + 16*p), 32'(rd_busy_b[p]), 32'h0);
         end
         model_step();
         @(negedge clk);
      end

      for (int i = 0; i < tbl.size(); i++) begin
         wr_en = tbl[i].we;
         wr_addr = {tbl[i].wa1, tbl[i].wa0};
         wr_data = {tbl[i].wd1, tbl[i].wd0};
         alloc_en = tbl[i].al;
         alloc_addr = tbl[i].aa;
         flush = tbl[i].fl;
         rd_addr = {5'd0, tbl[i].ra};
         #1;
         chk($sformatf("vec%0d a data", i), rd_data_a[31:0], tbl[i].ea);
         chk($sformatf("vec%0d a busy", i), 32'(rd_busy_a[0]), 32'(tbl[i].ba));
         chk($sformatf("vec%0d b data", i), rd_data_b[31:0], tbl[i].eb);
         chk($sformatf("vec%0d b busy", i), 32'(rd_busy_b[0]), 32'(tbl[i].bb));
         model_step();
         @(negedge clk);
      end

      // reset must override a same-cycle write and alloc
      rst = 1'b1;
      wr_en = 2'b11;
      wr_addr = {5'd6, 5'd5};
      wr_data = {32'h2, 32'h1};
      alloc_en = 1'b1;
      alloc_addr = 5'd8;
      model_step();
      @(negedge clk);
      rst = 1'b0;
      idle();
      rd_addr = {5'd8, 5'd5};
      #1;
      check_model("rstprio");
      model_step();
      @(negedge clk);

      for (int n = 0; n < 400; n++) begin
         wr_en = 2'($urandom);
         wr_addr = {raddr(), raddr()};
         wr_data = {32'($urandom), 32'($urandom)};
         alloc_en = $urandom_range(0, 2) == 0;
         alloc_addr = raddr();
         flush = $urandom_range(0, 15) == 0;
         rd_addr = {raddr(), raddr()};
         #1;
         check_model($sformatf("rnd%0d", n));
         model_step();
         @(negedge clk);
      end

`ifdef GPR_EXIT_CHECK_EN
      idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wr_en = 2'b11;
      wr_addr = {5'd10, 5'd17};
      wr_data = {32'h0, 32'd93};
      @(negedge clk);
      idle();
      ecall = 1'b1;
      #1;
      chk("halt before ecall", 32'(hv_a), 32'h0);
      @(negedge clk);
      ecall = 1'b0;
      #1;
      chk("halt valid", 32'(hv_a), 32'h1);
      chk("halt code", hc_a, 32'h0);
      chk("halt valid b", 32'(hv_b), 32'h1);
      wr_en = 2'b01;
      wr_addr = {5'd0, 5'd10};
      wr_data = {32'h0, 32'h3};
      @(negedge clk);
      idle();
      ecall = 1'b1;
      @(negedge clk);
      ecall = 1'b0;
      #1;
      chk("halt sticky valid", 32'(hv_a), 32'h1);
      chk("halt sticky code", hc_a, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("halt after rst", 32'(hv_a), 32'h0);
      chk("halt code rst", hc_b, 32'h0);
`endif

      $display("%0d/%0d checks passed", pass_n, total);
      $finish;
   end
endmodule
